// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//
// MEM-stage load/store unit. It sits directly upstream of the data
// write-sync stage. It accepts one load or store per handshake from the
// pipeline and drives the byte-addressed data bus. After every sub-word
// store it holds cs low for GAP_CYCLES cycles, because the downstream stage
// performs its read-merge-write-back only while cs is low. Load data is
// extracted from the big-endian bus word, extended, and registered for
// writeback.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_valid_i         pipeline presents a memory op
//   req_ready_o         op accepted this cycle (low only while in the gap)
//   req_we_i            0 load, 1 store
//   req_size_i          0 byte, 1 half, 2 word (3 behaves as word)
//   req_signed_i        loads: sign-extend when 1
//   req_addr_i          byte address
//   req_wdata_i         right-justified store data
//   data_address_o      bus byte address
//   data_cs_o           bus chip select
//   data_rw_o           0 read, 1 write
//   data_mode_o         0 byte, 1 half, 2 word
//   data_wdata_o        store data, non-zero only while cs && rw
//   data_bus_oe_o       tristate enable for the shared data bus (cs && rw)
//   data_rdata_i        bus read word, valid while cs=1, rw=0
//   load_valid_o        one-cycle pulse: load_data_o is valid
//   load_data_o         aligned and extended load result
//   misalign_o          one-cycle pulse for a rejected misaligned op
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int MISALIGN_TRAP = 1,
    parameter int GAP_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic [31:0] data_address_o,
    output logic        data_cs_o,
    output logic        data_rw_o,
    output logic [1:0]  data_mode_o,
    output logic [31:0] data_wdata_o,
    output logic        data_bus_oe_o,
    input  logic [31:0] data_rdata_i,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    // A zero gap would let a request raise cs while the downstream stage
    // still has a write-back pending, so at least one cycle is always kept.
    localparam int GAP_LOAD = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int CNT_W    = $clog2(GAP_LOAD + 1);
    localparam bit TRAP_EN  = (MISALIGN_TRAP != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [1:0]         size_eff_p0;
    logic [31:0]        addr_eff_p0;
    logic               misaligned_p0;
    logic               trap_p0;
    logic               hs_p0;
    logic               issue_p0;
    logic               load_issue_p0;
    logic               subword_store_p0;

    logic               vld_p1;
    logic               mis_p1;
    logic [31:0]        load_data_p1;

    // Selects the addressed field of a big-endian word (byte 0 / half 0 in
    // the most significant bits) and extends it to 32 bits.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [31:0] r;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[15:0] : word[31:16];
        case (size)
            2'd0:    r = sgn ? {{24{b[7]}}, b}  : {24'd0, b};
            2'd1:    r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // ---- p0: request decode (handshake cycle) ----
    always_comb begin
        size_eff_p0   = (req_size_i == 2'd3) ? 2'd2 : req_size_i;
        misaligned_p0 = ((size_eff_p0 == 2'd1) && req_addr_i[0]) ||
                        ((size_eff_p0 == 2'd2) && (req_addr_i[1:0] != 2'b00));
        // Masking is a no-op for aligned ops, so it also covers the
        // non-trapping mode where offending low bits are dropped.
        addr_eff_p0 = req_addr_i;
        if (size_eff_p0 == 2'd1) begin
            addr_eff_p0[0] = 1'b0;
        end else if (size_eff_p0 == 2'd2) begin
            addr_eff_p0[1:0] = 2'b00;
        end
        trap_p0          = TRAP_EN && misaligned_p0;
        hs_p0            = req_valid_i && req_ready_o;
        issue_p0         = hs_p0 && !trap_p0;
        load_issue_p0    = issue_p0 && !req_we_i;
        subword_store_p0 = issue_p0 && req_we_i && (size_eff_p0 != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (subword_store_p0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = CNT_W'(GAP_LOAD);
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        req_ready_o    = 1'b0;
        data_address_o = '0;
        data_cs_o      = 1'b0;
        data_rw_o      = 1'b0;
        data_mode_o    = 2'd0;
        data_wdata_o   = '0;
        data_bus_oe_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && !trap_p0) begin
                    data_address_o = addr_eff_p0;
                    data_cs_o      = 1'b1;
                    data_rw_o      = req_we_i;
                    data_mode_o    = size_eff_p0;
                    data_wdata_o   = req_we_i ? req_wdata_i : 32'd0;
                    data_bus_oe_o  = req_we_i;
                end
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

    // ---- p1: registered load result / misalign pulse ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            mis_p1       <= 1'b0;
            load_data_p1 <= '0;
        end else begin
            vld_p1 <= load_issue_p0;
            mis_p1 <= hs_p0 && trap_p0;
            if (load_issue_p0) begin
                load_data_p1 <= load_extend(data_rdata_i, addr_eff_p0[1:0],
                                            size_eff_p0, req_signed_i);
            end
        end
    end

    assign load_valid_o = vld_p1;
    assign load_data_o  = load_data_p1;
    assign misalign_o   = mis_p1;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [31:0] data_address_o;
    logic        data_cs_o;
    logic        data_rw_o;
    logic [1:0]  data_mode_o;
    logic [31:0] data_wdata_o;
    logic        data_bus_oe_o;
    logic [31:0] data_rdata_i;
    logic        load_valid_o;
    logic [31:0] load_data_o;
    logic        misalign_o;

    mem_stage_lsu #(.MISALIGN_TRAP(1), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .data_address_o(data_address_o), .data_cs_o(data_cs_o),
        .data_rw_o(data_rw_o), .data_mode_o(data_mode_o),
        .data_wdata_o(data_wdata_o), .data_bus_oe_o(data_bus_oe_o),
        .data_rdata_i(data_rdata_i),
        .load_valid_o(load_valid_o), .load_data_o(load_data_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    // Bus-side memory (written from the DUT's bus cycles) and the model's
    // own view of memory (written from the requested operations).
    logic [7:0] bus_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] rd_base;

    always_comb begin
        rd_base = {data_address_o[7:2], 2'b00};
        data_rdata_i = 32'd0;
        if (data_cs_o && !data_rw_o)
            data_rdata_i = {bus_mem[rd_base], bus_mem[rd_base + 8'd1],
                            bus_mem[rd_base + 8'd2], bus_mem[rd_base + 8'd3]};
    end

    int checks = 0;
    int errors = 0;
    int gap_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] eff_size(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

    function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
        int s = int'(eff_size(size));
        return (s == 1 && addr % 2 != 0) || (s == 2 && addr % 4 != 0);
    endfunction

    // Expected load value straight from the model memory, big-endian.
    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr);
        logic [7:0]  a = addr[7:0];
        logic [31:0] v;
        case (eff_size(size))
            2'd0: begin
                v = {24'd0, ref_mem[a]};
                if (sgn && v >= 32'h80) v = v + 32'hFFFFFF00;
            end
            2'd1: begin
                v = {16'd0, ref_mem[a], ref_mem[a + 8'd1]};
                if (sgn && v >= 32'h8000) v = v + 32'hFFFF0000;
            end
            default: v = {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
        logic [7:0] a = addr[7:0];
        int n = (eff_size(size) == 2'd0) ? 1 : (eff_size(size) == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++)
            ref_mem[a + 8'(i)] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    task automatic bus_store(input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] wd);
        logic [7:0] a = addr[7:0];
        int n = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++)
            bus_mem[a + 8'(i)] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        logic [7:0] a = {addr[7:2], 2'b00};
        for (int i = 0; i < 4; i++) begin
            bus_mem[a + 8'(i)] = 8'(word >> (24 - 8 * i));
            ref_mem[a + 8'(i)] = 8'(word >> (24 - 8 * i));
        end
    endtask

    // Entered and left at posedge+1.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid_i = 1'b0;
            #2;
            chk("idle_cs", 32'(data_cs_o), 32'd0);
            @(posedge clk); #1;
            chk("idle_load_valid", 32'(load_valid_o), 32'd0);
            chk("idle_misalign", 32'(misalign_o), 32'd0);
            if (gap_left > 0) gap_left--;
        end
    endtask

    task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
        int          stalls = 0;
        bit          mis = is_mis(size, addr);
        logic [31:0] ea;
        logic [31:0] exp_ld;
        ea = (eff_size(size) == 2'd2) ? (addr & ~32'd3) :
             (eff_size(size) == 2'd1) ? (addr & ~32'd1) : addr;
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
        req_signed_i = sgn; req_addr_i = addr; req_wdata_i = wd;
        #2;
        while (!req_ready_o && stalls < 20) begin
            chk({tag, " gap_cs"}, 32'(data_cs_o), 32'd0);
            stalls++;
            @(posedge clk); #3;
        end
        chk({tag, " stall"}, 32'(stalls), 32'(gap_left));
        gap_left = 0;
        if (mis) begin
            chk({tag, " trap_cs"}, 32'(data_cs_o), 32'd0);
        end else begin
            chk({tag, " cs"}, 32'(data_cs_o), 32'd1);
            chk({tag, " rw"}, 32'(data_rw_o), 32'(we));
            chk({tag, " mode"}, 32'(data_mode_o), 32'(eff_size(size)));
            chk({tag, " addr"}, data_address_o, ea);
            chk({tag, " wdata"}, data_wdata_o, we ? wd : 32'd0);
            chk({tag, " oe"}, 32'(data_bus_oe_o), 32'(we));
            if (data_cs_o && data_rw_o) bus_store(data_mode_o, data_address_o, data_wdata_o);
            if (we) begin
                ref_store(size, ea, wd);
                if (eff_size(size) != 2'd2) gap_left = GAP;
            end
        end
        exp_ld = ref_load(size, sgn, ea);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk({tag, " load_valid"}, 32'(load_valid_o), 32'(!mis && !we));
        chk({tag, " misalign"}, 32'(misalign_o), 32'(mis));
        if (!mis && !we) chk({tag, " load_data"}, load_data_o, exp_ld);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [31:0] exp;
        logic        exp_mis;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h123456F0, 32'hFFFFFFF0, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h123456F0, 32'h000000F0, 1'b0};
        tbl[3] = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h12348001, 32'hFFFF8001, 1'b0};
        tbl[4] = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'h87654321, 32'h00008765, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h80000000, 32'hFFFFFF80, 1'b0};
        tbl[6] = '{1'b0, 2'd0, 1'b0, 32'h15, 32'h0, 32'h007F0000, 32'h0000007F, 1'b0};
        tbl[7] = '{1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 32'h01020304, 32'h0, 1'b1};
        tbl[8] = '{1'b0, 2'd3, 1'b0, 32'h24, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};

        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end

        rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
        req_signed_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(req_ready_o), 32'd1);
        chk("reset cs", 32'(data_cs_o), 32'd0);
        chk("reset load_valid", 32'(load_valid_o), 32'd0);
        chk("reset load_data", load_data_o, 32'd0);
        chk("reset misalign", 32'(misalign_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            preload(tbl[i].addr, tbl[i].pre);
            do_op(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, $sformatf("tbl%0d", i));
            if (!tbl[i].exp_mis) chk($sformatf("tbl%0d expected", i), load_data_o, tbl[i].exp);
            idle(2);
        end

        // Byte store then immediate word load: one stall, merged byte visible.
        preload(32'h20, 32'h11223344);
        do_op(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AB, "merge_store");
        do_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "merge_load");
        chk("merge value", load_data_o, 32'h11AB3344);
        idle(1);

        // Back-to-back word stores, then read one back.
        do_op(1'b1, 2'd2, 1'b0, 32'h00, 32'hA0A1A2A3, "b2b0");
        do_op(1'b1, 2'd2, 1'b0, 32'h04, 32'hB0B1B2B3, "b2b1");
        do_op(1'b1, 2'd2, 1'b0, 32'h08, 32'hC0C1C2C3, "b2b2");
        do_op(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, "b2b_rd");
        chk("b2b value", load_data_o, 32'hB0B1B2B3);
        idle(1);

        // Misaligned half, then a normal op immediately after.
        do_op(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, "mis_half");
        do_op(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, "after_mis");
        chk("after_mis value", load_data_o, 32'hC0C1C2C3);
        idle(1);

        // Reset asserted while in the gap.
        do_op(1'b1, 2'd1, 1'b0, 32'h40, 32'h00005A5A, "rst_store");
        chk("gap ready", 32'(req_ready_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_gap cs", 32'(data_cs_o), 32'd0);
        chk("rst_gap oe", 32'(data_bus_oe_o), 32'd0);
        chk("rst_gap load_valid", 32'(load_valid_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_gap ready_after", 32'(req_ready_o), 32'd1);
        gap_left = 0;
        @(posedge clk); #1;
        do_op(1'b0, 2'd1, 1'b0, 32'h40, 32'h0, "rst_readback");
        chk("rst_readback value", load_data_o, 32'h00005A5A);

        // Randomized ops against the reference model.
        for (int n = 0; n < 400; n++) begin
            do_op(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
                  $urandom, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
